// File: rtl/uart_pkg.sv
// Shared encodings, FSM state type and frame-format helpers for the UART transmitter.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;

    localparam logic [2:0] PARITY_NONE  = 3'b000;
    localparam logic [2:0] PARITY_EVEN  = 3'b001;
    localparam logic [2:0] PARITY_ODD   = 3'b010;
    localparam logic [2:0] PARITY_MARK  = 3'b011;
    localparam logic [2:0] PARITY_SPACE = 3'b100;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // Last sub-bit tick index of an ordinary 16-tick bit.
    localparam logic [4:0] BIT_LAST = 5'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Index of the final data bit for a given data-bits code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
        case (dbits)
            DBITS_5: return 3'd4;
            DBITS_6: return 3'd5;
            DBITS_7: return 3'd6;
            DBITS_8: return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

    // Last tick index of the stop period: 16, 24 or 32 ticks.
    function automatic logic [4:0] stop_last(input logic [1:0] stop);
        case (stop)
            STOP_1:   return 5'd15;
            STOP_1P5: return 5'd23;
            STOP_2:   return 5'd31;
            default:  return 5'd31;
        endcase
    endfunction

    // Unknown parity codes behave as "none".
    function automatic logic parity_enabled(input logic [2:0] par);
        return (par == PARITY_EVEN) || (par == PARITY_ODD) ||
               (par == PARITY_MARK) || (par == PARITY_SPACE);
    endfunction

    // Parity covers only the bits actually sent; unused upper bits are masked off.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] dbits,
                                        input logic [2:0] par);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - dbits);
        x    = ^(data & mask);
        case (par)
            PARITY_EVEN: return x;
            PARITY_ODD:  return ~x;
            PARITY_MARK: return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable sub-bit tick generator: one tick every div_i+1 clocks.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Terminal count; >= guards against a counter left above a smaller divisor.
    assign tick_o = (cnt_q >= div_i);

    // Wrap on terminal count, restart from zero on clear.
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: input FIFO, frame FSM with break, registered TX line.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_dbits_i,
    input  logic [2:0]       cfg_parity_i,
    input  logic [1:0]       cfg_stop_i,
    input  logic             break_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             uart_tx_o,
    output logic             uart_busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Producer handshake: a byte transfers on any cycle with s_valid_i && s_ready_o;
    // s_ready_o depends only on the FIFO being not full, never on a same-cycle pop.
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             fifo_full, fifo_empty, push, pop;

    uart_state_e      state_q, state_d;
    logic [4:0]       tcnt_q, tcnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       dbits_q, dbits_d;
    logic [2:0]       parity_q, parity_d;
    logic [1:0]       stop_q, stop_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d;
    logic             clr, tick;

    assign fifo_full    = (count_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign push         = s_valid_i && !fifo_full;
    assign s_ready_o    = !fifo_full;
    assign fifo_level_o = count_q;
    assign uart_tx_o    = tx_q;
    assign uart_busy_o  = (state_q != ST_IDLE) || !fifo_empty;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (clr),
        .div_i   (div_q),
        .tick_o  (tick)
    );

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    // Frame sequencing: next state, frame-start latching and sub-bit counting.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        dbits_d  = dbits_q;
        parity_d = parity_q;
        stop_d   = stop_q;
        div_d    = div_q;
        pop      = 1'b0;
        clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (break_i) begin
                    state_d = ST_BREAK;
                end else if (enable_i && !fifo_empty) begin
                    pop      = 1'b1;
                    clr      = 1'b1;
                    data_d   = mem_q[rd_ptr_q];
                    dbits_d  = cfg_dbits_i;
                    parity_d = cfg_parity_i;
                    stop_d   = cfg_stop_i;
                    div_d    = cfg_div_i;
                    tcnt_d   = '0;
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == BIT_LAST) begin
                        tcnt_d  = '0;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt_q == BIT_LAST) begin
                        tcnt_d = '0;
                        if (bit_q == last_bit_idx(dbits_q)) begin
                            state_d = parity_enabled(parity_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (tcnt_q == BIT_LAST) begin
                        tcnt_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == stop_last(stop_q)) begin
                        tcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
            end
            ST_BREAK: begin
                if (!break_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level for the state being entered, so the registered output never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_d];
            ST_PARITY: tx_d = parity_bit(data_q, dbits_q, parity_q);
            ST_STOP:   tx_d = 1'b1;
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

    // State, frame context, FIFO pointers and the TX line register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            tcnt_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            dbits_q  <= DBITS_8;
            parity_q <= PARITY_NONE;
            stop_q   <= STOP_1;
            div_q    <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            dbits_q  <= dbits_d;
            parity_q <= parity_d;
            stop_q   <= stop_d;
            div_q    <= div_d;
            tx_q     <= tx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: waveform-level reference model checked every cycle,
// directed frame-format cases with literal expectations, then random traffic.
module tb_uart_tx_cfg;

    localparam int DEPTH = 8;
    localparam int DIV_W = 16;
    localparam int LVL_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [1:0]       cfg_dbits = 2'b11;
    logic [2:0]       cfg_parity = 3'b000;
    logic [1:0]       cfg_stop = 2'b00;
    logic             break_in = 1'b0;
    logic [7:0]       s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             uart_tx;
    logic             uart_busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W), .LVL_W(LVL_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .cfg_div_i    (cfg_div),
        .cfg_dbits_i  (cfg_dbits),
        .cfg_parity_i (cfg_parity),
        .cfg_stop_i   (cfg_stop),
        .break_i      (break_in),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .fifo_level_o (fifo_level),
        .uart_tx_o    (uart_tx),
        .uart_busy_o  (uart_busy)
    );

    // Clock / cycle counter
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model holds the expected line value for every future clock of the
    // current frame, plus one trailing idle cycle before the next decision.
    logic [7:0] m_fifo[$];
    bit         m_wave[$];
    bit         m_in_break = 1'b0;
    bit         m_tx = 1'b1;
    bit         m_do_push;

    function automatic bit exp_parity(input int b, input int n, input int code);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += (b >> i) & 1;
        case (code)
            1: return bit'(ones % 2);
            2: return bit'(1 - ones % 2);
            3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void build_frame(input logic [7:0] b);
        int n, clk_per_tick, stop_ticks, code;
        n = 5 + int'(cfg_dbits);
        clk_per_tick = int'(cfg_div) + 1;
        code = int'(cfg_parity);
        stop_ticks = (cfg_stop == 2'b00) ? 16 : (cfg_stop == 2'b01) ? 24 : 32;
        for (int k = 0; k < 16 * clk_per_tick; k++) m_wave.push_back(1'b0);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 16 * clk_per_tick; k++) m_wave.push_back(b[i]);
        if (code >= 1 && code <= 4)
            for (int k = 0; k < 16 * clk_per_tick; k++)
                m_wave.push_back(exp_parity(int'(b), n, code));
        for (int k = 0; k < stop_ticks * clk_per_tick; k++) m_wave.push_back(1'b1);
        m_wave.push_back(1'b1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_wave.delete();
            m_in_break = 1'b0;
            m_tx = 1'b1;
        end else begin
            m_do_push = s_valid && (m_fifo.size() < DEPTH);
            if (m_wave.size() > 0) begin
                m_tx = m_wave.pop_front();
            end else if (m_in_break) begin
                if (!break_in) begin
                    m_in_break = 1'b0;
                    m_tx = 1'b1;
                end else begin
                    m_tx = 1'b0;
                end
            end else if (break_in) begin
                m_in_break = 1'b1;
                m_tx = 1'b0;
            end else if (enable && m_fifo.size() > 0) begin
                build_frame(m_fifo.pop_front());
                m_tx = m_wave.pop_front();
            end else begin
                m_tx = 1'b1;
            end
            if (m_do_push) m_fifo.push_back(s_data);
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        check("tx", uart_tx, m_tx);
        check("busy", uart_busy, (m_wave.size() > 0) || m_in_break || (m_fifo.size() > 0));
        check("ready", s_ready, m_fifo.size() < DEPTH);
        check("level", fifo_level, m_fifo.size());
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] b);
        int n = 0;
        while (!s_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("push_ready", s_ready, 1);
        s_data = b;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_fall(output int t0);
        int n = 0;
        while (uart_tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        check("frame_start", uart_tx, 0);
    endtask

    // Sample point k clocks after the edge that dropped the line.
    task automatic at_k(input int t0, input int k);
        @(negedge clk);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (uart_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, uart_busy, 0);
    endtask

    task automatic set_cfg(input int dv, input int db, input int par, input int st);
        cfg_div = DIV_W'(dv);
        cfg_dbits = 2'(db);
        cfg_parity = 3'(par);
        cfg_stop = 2'(st);
    endtask

    // ---------------- stimulus ----------------
    int t0;
    int n;
    int brk_left;
    logic [9:0] pat;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", uart_busy, 0);
        check("rst_ready", s_ready, 1);
        check("rst_level", fifo_level, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 8N1, div=0, 0xA5
        set_cfg(0, 3, 0, 0);
        enable = 1'b1;
        push(8'hA5);
        wait_fall(t0);
        pat = 10'b1_10100101_0;
        for (int i = 0; i < 10; i++) begin
            at_k(t0, i * 16 + 8);
            check("a5_bit", uart_tx, pat[i]);
        end
        at_k(t0, 159);
        check("a5_busy_last", uart_busy, 1);
        at_k(t0, 160);
        check("a5_busy_fall", uart_busy, 0);

        // 7E2, div=3, 0xFF then 0x80
        set_cfg(3, 2, 1, 2);
        push(8'hFF);
        wait_fall(t0);
        at_k(t0, 96);  check("ff_d0", uart_tx, 1);
        at_k(t0, 480); check("ff_d6", uart_tx, 1);
        at_k(t0, 544); check("ff_par", uart_tx, 1);
        at_k(t0, 672); check("ff_stop2", uart_tx, 1);
        at_k(t0, 703); check("ff_busy_last", uart_busy, 1);
        at_k(t0, 704); check("ff_busy_fall", uart_busy, 0);
        push(8'h80);
        wait_fall(t0);
        at_k(t0, 480); check("80_d6", uart_tx, 0);
        at_k(t0, 544); check("80_par", uart_tx, 0);
        at_k(t0, 704); check("80_busy_fall", uart_busy, 0);

        // 5O1.5, div=1, 0x1F
        set_cfg(1, 0, 2, 1);
        push(8'h1F);
        wait_fall(t0);
        at_k(t0, 176); check("1f_d4", uart_tx, 1);
        at_k(t0, 208); check("1f_par", uart_tx, 0);
        at_k(t0, 224); check("1f_stop_begin", uart_tx, 1);
        at_k(t0, 271); check("1f_busy_last", uart_busy, 1);
        at_k(t0, 272); check("1f_busy_fall", uart_busy, 0);

        // FIFO full with enable low, ninth byte held, then drained in order
        set_cfg(0, 3, 0, 0);
        @(posedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        s_data = 8'h5A;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("full_ready", s_ready, 0);
        check("full_level", fifo_level, 8);
        check("full_line", uart_tx, 1);
        @(posedge clk); #1;
        enable = 1'b1;
        n = 0;
        while (!s_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("ninth_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_idle("full_drain", 5000);

        // break mid-frame, pending byte follows the break
        push(8'h3C);
        push(8'hC3);
        wait_fall(t0);
        at_k(t0, 40);
        break_in = 1'b1;
        at_k(t0, 150); check("brk_frame_continues", uart_tx, 1);
        at_k(t0, 160); check("brk_idle_gap", uart_tx, 1);
        at_k(t0, 161); check("brk_low", uart_tx, 0);
        at_k(t0, 200); check("brk_hold", uart_tx, 0);
        break_in = 1'b0;
        at_k(t0, 201); check("brk_release", uart_tx, 1);
        at_k(t0, 202); check("brk_pending_start", uart_tx, 0);
        wait_idle("brk_drain", 2000);

        // reset during DATA
        push(8'h00);
        push(8'h11);
        push(8'h22);
        wait_fall(t0);
        at_k(t0, 50);
        check("pre_rst_level", fifo_level, 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_busy", uart_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("post_rst_idle", uart_tx, 1);

        // random traffic
        brk_left = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 199) == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 7), $urandom_range(0, 3));
            s_valid = ($urandom_range(0, 99) < 3);
            s_data = 8'($urandom);
            if ($urandom_range(0, 499) == 0) enable = !enable;
            if (brk_left > 0) begin
                brk_left--;
                break_in = (brk_left > 0);
            end else if ($urandom_range(0, 2999) == 0) begin
                brk_left = $urandom_range(1, 60);
                break_in = 1'b1;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        break_in = 1'b0;
        enable = 1'b1;
        wait_idle("random_drain", 20000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
